// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I core: sequencer states, opcodes,
// alu_op values and datapath mux selects.
package core_pkg;

    localparam int unsigned OP_W      = 7;
    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned RES_W     = 2;
    localparam int unsigned IMM_SRC_W = 3;
    localparam int unsigned STATE_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12
    } t_state;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ITYPE  = 3'b011;

    localparam logic ADR_SRC_PC     = 1'b0;
    localparam logic ADR_SRC_ALUOUT = 1'b1;

    localparam logic [SRC_W-1:0] SRC_A_PC    = 2'b00;
    localparam logic [SRC_W-1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [SRC_W-1:0] SRC_A_RS1   = 2'b10;

    localparam logic [SRC_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SRC_W-1:0] SRC_B_IMM  = 2'b01;
    localparam logic [SRC_W-1:0] SRC_B_FOUR = 2'b10;

    localparam logic [RES_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [RES_W-1:0] RES_DATA   = 2'b01;
    localparam logic [RES_W-1:0] RES_ALU    = 2'b10;
    localparam logic [RES_W-1:0] RES_IMM    = 2'b11;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Selects the immediate format from the opcode; independent of sequencer state.
module imm_src_decoder
    import core_pkg::*;
(
    input  logic [OP_W-1:0]      i_op,
    output logic [IMM_SRC_W-1:0] o_imm_src
);

    // R-type and unknown opcodes fall back to I format; their immediate is unused.
    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_STORE:           o_imm_src = IMM_S;
            OP_BRANCH:          o_imm_src = IMM_B;
            OP_JAL:             o_imm_src = IMM_J;
            OP_LUI, OP_AUIPC:   o_imm_src = IMM_U;
            default:            o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// Main sequencer of the multicycle RV32I core: walks the shared datapath through
// fetch/decode/execute/memory/writeback, stalling in memory states until ready.
module multicycle_fsm
    import core_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [OP_W-1:0]      i_op,
    input  logic                 i_branch_taken,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_adr_src,
    output logic                 o_instr_we,
    output logic                 o_pc_we,
    output logic                 o_reg_we,
    output logic [SRC_W-1:0]     o_alu_src_a,
    output logic [SRC_W-1:0]     o_alu_src_b,
    output logic [ALU_OP_W-1:0]  o_alu_op,
    output logic [RES_W-1:0]     o_result_src,
    output logic [IMM_SRC_W-1:0] o_imm_src,
    output logic                 o_illegal_instr,
    output logic                 o_instr_done
);

    t_state state;
    t_state state_nxt;

    imm_src_decoder u_imm_src_decoder (
        .i_op      (i_op),
        .o_imm_src (o_imm_src)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Moore decode of state; only the memory-ready and branch-taken paths are Mealy.
    always_comb begin
        state_nxt       = state;
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_adr_src       = ADR_SRC_PC;
        o_instr_we      = 1'b0;
        o_pc_we         = 1'b0;
        o_reg_we        = 1'b0;
        o_alu_src_a     = SRC_A_PC;
        o_alu_src_b     = SRC_B_RS2;
        o_alu_op        = ALU_OP_ADD;
        o_result_src    = RES_ALUOUT;
        o_illegal_instr = 1'b0;
        o_instr_done    = 1'b0;

        case (state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_adr_src    = ADR_SRC_PC;
                o_alu_src_a  = SRC_A_PC;
                o_alu_src_b  = SRC_B_FOUR;
                o_alu_op     = ALU_OP_ADD;
                o_result_src = RES_ALU;
                if (i_mem_ready) begin
                    o_instr_we = 1'b1;
                    o_pc_we    = 1'b1;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_a = SRC_A_OLDPC;
                o_alu_src_b = SRC_B_IMM;
                o_alu_op    = ALU_OP_ADD;
                case (i_op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECUTER;
                    OP_ITYPE:          state_nxt = S_EXECUTEI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_AUIPC:          state_nxt = S_ALUWB;
                    OP_FENCE: begin
                        o_instr_done = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                    default: begin
                        o_illegal_instr = 1'b1;
                        o_instr_done    = 1'b1;
                        state_nxt       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = SRC_A_RS1;
                o_alu_src_b = SRC_B_IMM;
                o_alu_op    = ALU_OP_ADD;
                state_nxt   = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_mem_req = 1'b1;
                o_adr_src = ADR_SRC_ALUOUT;
                if (i_mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_we     = 1'b1;
                o_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWRITE: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_adr_src = ADR_SRC_ALUOUT;
                if (i_mem_ready) begin
                    o_instr_done = 1'b1;
                    state_nxt    = S_FETCH;
                end
            end
            S_EXECUTER: begin
                o_alu_src_a = SRC_A_RS1;
                o_alu_src_b = SRC_B_RS2;
                o_alu_op    = ALU_OP_RTYPE;
                state_nxt   = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_alu_src_a = SRC_A_RS1;
                o_alu_src_b = SRC_B_IMM;
                o_alu_op    = ALU_OP_ITYPE;
                state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                o_result_src = RES_ALUOUT;
                o_reg_we     = 1'b1;
                o_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a  = SRC_A_RS1;
                o_alu_src_b  = SRC_B_RS2;
                o_alu_op     = ALU_OP_BRANCH;
                o_result_src = RES_ALUOUT;
                o_pc_we      = i_branch_taken;
                o_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JALR: begin
                o_alu_src_a = SRC_A_RS1;
                o_alu_src_b = SRC_B_IMM;
                o_alu_op    = ALU_OP_ADD;
                state_nxt   = S_JAL;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link OldPC+4.
                o_alu_src_a  = SRC_A_OLDPC;
                o_alu_src_b  = SRC_B_FOUR;
                o_alu_op     = ALU_OP_ADD;
                o_result_src = RES_ALUOUT;
                o_pc_we      = 1'b1;
                state_nxt    = S_ALUWB;
            end
            S_LUI: begin
                o_result_src = RES_IMM;
                o_reg_we     = 1'b1;
                o_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset withdraws any outstanding request and blocks every write.
        if (i_rst) begin
            o_mem_req       = 1'b0;
            o_mem_we        = 1'b0;
            o_adr_src       = ADR_SRC_PC;
            o_instr_we      = 1'b0;
            o_pc_we         = 1'b0;
            o_reg_we        = 1'b0;
            o_alu_src_a     = SRC_A_PC;
            o_alu_src_b     = SRC_B_RS2;
            o_alu_op        = ALU_OP_ADD;
            o_result_src    = RES_ALUOUT;
            o_illegal_instr = 1'b0;
            o_instr_done    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_fsm.md
Name: multicycle_fsm

Overview:
- Main sequencer for the multicycle RV32I core.
- Steps the shared datapath (one ALU, one memory port, register file, PC/OldPC/Instr/ALUOut/Data registers) through fetch, decode, execute, memory and writeback, one state per cycle.
- Holds in memory states until the memory/cache port handshakes.
- Its alu_op output drives the existing alu_decoder; the FSM replaces main_decoder in this core.

Parameters:
- None. All opcode, alu_op and mux-select encodings come from the shared package.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_op  in  7  opcode from Instr register
- i_branch_taken  in  1  branch condition result from datapath comparator
- i_mem_ready  in  1  memory port completes the current request this cycle
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  request is a store
- o_adr_src  out  1  0 = PC, 1 = ALUOut
- o_instr_we  out  1  load Instr and OldPC registers
- o_pc_we  out  1  PC write
- o_reg_we  out  1  register file write
- o_alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- o_alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- o_alu_op  out  3  000 add, 001 branch, 010 R-type, 011 I-type
- o_result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result, 11 = imm
- o_imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- o_illegal_instr  out  1  one-cycle pulse on unknown opcode
- o_instr_done  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- Reset: state = FETCH. During reset, all write enables, o_mem_req and both pulses are 0.
- Reset mid-request drops the request. The memory side must tolerate request withdrawal.
- Output timing:
  - Outputs are decoded from state, with Mealy gating only where noted.
  - Any output not listed for a state is 0, except o_imm_src.
  - o_imm_src is purely combinational from i_op in every state.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=000, result_src=10.
  - i_mem_ready=1: instr_we=1 and pc_we=1 (PC <= PC+4, same cycle), then go to DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE: src_a=01, src_b=01, alu_op=000, so ALUOut = OldPC+imm. Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB (AUIPC result already in ALUOut)
  - 0001111 (fence) -> FETCH, with instr_done=1
  - any other opcode -> FETCH, with illegal_instr=1 and instr_done=1
- MEMADR: src_a=10, src_b=01, alu_op=000. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for ready, then go to MEMWB.
- MEMWB: result_src=01, reg_we=1, instr_done=1, then go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1, all held stable until ready. On ready: instr_done=1, go to FETCH.
- EXECUTER: src_a=10, src_b=00, alu_op=010, then go to ALUWB.
- EXECUTEI: src_a=10, src_b=01, alu_op=011, then go to ALUWB.
- ALUWB: result_src=00, reg_we=1, instr_done=1, then go to FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=001, result_src=00, pc_we=i_branch_taken, instr_done=1, then go to FETCH.
- JALR: src_a=10, src_b=01, alu_op=000 (ALUOut <= rs1+imm), then go to JAL.
- JAL: src_a=01, src_b=10, alu_op=000, result_src=00, pc_we=1. PC <= ALUOut target while ALUOut <= OldPC+4. Then go to ALUWB.
- LUI: result_src=11, reg_we=1, instr_done=1, then go to FETCH.
- Handshake rules:
  - i_mem_ready is ignored whenever mem_req=0.
  - Stall length is unbounded; there is no timeout.
  - ready arriving in the first cycle of a memory state gives zero wait.
- Cycles per instruction with zero-wait memory:
  - load 5
  - store 4
  - R/I 4
  - branch 3
  - jal 4
  - jalr 5
  - lui 3
  - auipc 3
  - fence/illegal 2
- State register: one-hot or binary, implementer's choice.
- Illegal state: any unreachable encoding recovers to FETCH on the next clock.

Decomposition:
- Package core_pkg holds:
  - state enum t_state
  - opcode constants
  - alu_op constants (shared with alu_decoder)
  - mux-select constants for adr_src, alu_src_a/b, result_src, imm_src
- Sub-module imm_src_decoder: combinational i_op -> o_imm_src, instantiated once.
- Everything else lives in the single FSM module: next-state block plus output block.

Test Plan:
- Reset held 2 cycles, then released with i_mem_ready=1 and i_op=0110011 (add): states FETCH -> DECODE -> EXECUTER -> ALUWB. reg_we=1 in cycle 4 only; instr_done pulses once; pc_we only in cycle 1.
- Load with i_mem_ready low for 3 cycles in FETCH and 2 cycles in MEMREAD: mem_req held each waiting cycle, no instr_we/pc_we until ready. Total 10 cycles; MEMWB result_src=01.
- Store with ready delayed 4 cycles: mem_we=1, adr_src=1 stable for all 5 MEMWRITE cycles; reg_we never asserted; back to FETCH after ready.
- Branch 1100011:
  - i_branch_taken=1: pc_we=1 in BRANCH.
  - i_branch_taken=0: pc_we=0.
  - Both cases: 3 cycles, alu_op=001 in BRANCH.
- jalr 1100111: JALR (src_a=10, src_b=01) -> JAL (pc_we=1, src_a=01, src_b=10) -> ALUWB (reg_we=1); 5 cycles total.
- i_op=1111111: illegal_instr pulses exactly once in DECODE, no reg/mem/pc writes, FETCH next. Also assert i_rst during MEMREAD stall: mem_req=0 the next cycle, then FETCH.
